sram_1rw1r_wmask: RTL and testbench

Parametrised successor to the fixed 32x128 single-port macro model. Port 0 is read/write with a per-segment write mask; port 1 is read-only. Both ports register their inputs on posedge clk0 and access the array on negedge clk0. Adds async reset, read-valid strobes, deterministic write-first forwarding on cross-port collision, and a collision flag. Used as the behavioural model for register-file and buffer macros in the SoC memory subsystem.

---
 rtl/sram_pkg.sv | 33 +++
 rtl/sram_wmask_merge.sv | 39 +++
 rtl/sram_1rw1r_wmask.sv | 189 ++++++++++++++++++
 tb/tb_sram_1rw1r_wmask.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, constants and helpers for sram_1rw1r_wmask
//
// Purpose : segment-count helper, per-segment parity helper and the read
//           response record used by both read ports.
// Contents: num_wmasks(), seg_parity(), SRAM_MAX_DW, SRAM_MAX_SEG,
//           SRAM_DEF_NUM_WMASKS, rd_resp_t.
package sram_pkg;

    // Upper bounds that size the shared record and the parity helper input.
    localparam int unsigned SRAM_MAX_DW  = 256;
    localparam int unsigned SRAM_MAX_SEG = 64;

    function automatic int unsigned num_wmasks(input int unsigned data_w,
                                               input int unsigned seg_w);
        return data_w / seg_w;
    endfunction

    // Segment count of the default 32-bit word with 8-bit segments.
    localparam int unsigned SRAM_DEF_NUM_WMASKS = num_wmasks(32, 8);

    // Even parity of one segment; callers zero-extend, which leaves XOR intact.
    function automatic logic seg_parity(input logic [SRAM_MAX_SEG-1:0] seg);
        return ^seg;
    endfunction

    // Only data[DATA_WIDTH-1:0] is meaningful; upper bits stay zero.
    typedef struct packed {
        logic [SRAM_MAX_DW-1:0] data;
        logic                   valid;
        logic                   perr;
    } rd_resp_t;

endpackage

// File: rtl/sram_wmask_merge.sv
// rtl/sram_wmask_merge.sv - combinational segment merge with per-segment parity
//
// Purpose : builds the word that a masked write leaves in the array, and the
//           even parity of every segment of that merged word.
// Ports   : old_i    current array word
//           new_i    write data
//           mask_i   per-segment select, 1 = take new_i
//           merged_o merged word
//           par_o    even parity of each merged segment
module sram_wmask_merge
    import sram_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 32,
    parameter  int unsigned WMASK_WIDTH = 8,
    localparam int unsigned NUM_WMASKS  = num_wmasks(DATA_WIDTH, WMASK_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] new_i,
    input  logic [NUM_WMASKS-1:0] mask_i,
    output logic [DATA_WIDTH-1:0] merged_o,
    output logic [NUM_WMASKS-1:0] par_o
);

    for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_seg
        logic [SRAM_MAX_SEG-1:0] seg_ext;

        assign merged_o[g*WMASK_WIDTH +: WMASK_WIDTH] =
            mask_i[g] ? new_i[g*WMASK_WIDTH +: WMASK_WIDTH]
                      : old_i[g*WMASK_WIDTH +: WMASK_WIDTH];

        always_comb begin
            seg_ext                  = '0;
            seg_ext[WMASK_WIDTH-1:0] = merged_o[g*WMASK_WIDTH +: WMASK_WIDTH];
        end

        assign par_o[g] = seg_parity(seg_ext);
    end

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// rtl/sram_1rw1r_wmask.sv - 1RW + 1R behavioural SRAM with segment write mask
//
// Purpose : inputs registered on posedge clk0, array accessed on negedge clk0,
//           so read data is sampled valid at the following posedge.
//           A port-1 read of the address port 0 writes in the same cycle
//           returns the merged word (write-first) and raises coll1.
// Option  : SRAM_PARITY_EN adds one even-parity bit per segment; otherwise
//           perr0/perr1 are tied to 0.
// Ports   : clk0, rst0_n (async, active-low)
//           port 0: csb0, web0, wmask0, addr0, din0 -> dout0, rvalid0, perr0
//           port 1: csb1, addr1 -> dout1, rvalid1, coll1, perr1
module sram_1rw1r_wmask
    import sram_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 32,
    parameter  int unsigned ADDR_WIDTH  = 7,
    parameter  int unsigned RAM_DEPTH   = 1 << ADDR_WIDTH,
    parameter  int unsigned WMASK_WIDTH = 8,
    localparam int unsigned NUM_WMASKS  = num_wmasks(DATA_WIDTH, WMASK_WIDTH)
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  rvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  rvalid1,
    output logic                  coll1,
    output logic                  perr0,
    output logic                  perr1
);

    logic                  csb0_q;
    logic                  web0_q;
    logic [NUM_WMASKS-1:0] wmask0_q;
    logic [ADDR_WIDTH-1:0] addr0_q;
    logic [DATA_WIDTH-1:0] din0_q;
    logic                  csb1_q;
    logic [ADDR_WIDTH-1:0] addr1_q;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    rd_resp_t resp0_d, resp0_q;
    rd_resp_t resp1_d, resp1_q;
    logic     coll1_d, coll1_q;

    logic                  wr0, rd0, rd1;
    logic [DATA_WIDTH-1:0] word0, word1, merged, rd1_data;
    logic [NUM_WMASKS-1:0] merged_par;
    logic                  perr0_chk, perr1_chk;

    // Input registers. Reset parks both chip selects high, so an access
    // captured before a mid-cycle reset is dropped before the negedge.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            din0_q   <= '0;
            csb1_q   <= 1'b1;
            addr1_q  <= '0;
        end else begin
            csb0_q   <= csb0;
            web0_q   <= web0;
            wmask0_q <= wmask0;
            addr0_q  <= addr0;
            din0_q   <= din0;
            csb1_q   <= csb1;
            addr1_q  <= addr1;
        end
    end

    assign wr0     = !csb0_q && !web0_q;
    assign rd0     = !csb0_q &&  web0_q;
    assign rd1     = !csb1_q;
    assign coll1_d = wr0 && rd1 && (addr0_q == addr1_q);

    assign word0 = mem_q[addr0_q];
    assign word1 = mem_q[addr1_q];

    // One merge serves both the array write and the forwarded port-1 word.
    sram_wmask_merge #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WMASK_WIDTH (WMASK_WIDTH)
    ) u_merge (
        .old_i    (word0),
        .new_i    (din0_q),
        .mask_i   (wmask0_q),
        .merged_o (merged),
        .par_o    (merged_par)
    );

    assign rd1_data = coll1_d ? merged : word1;

`ifdef SRAM_PARITY_EN
    logic [NUM_WMASKS-1:0] par_mem_q [RAM_DEPTH];
    logic [NUM_WMASKS-1:0] wr_par, stored0, stored1, chk0, chk1;

    // Unwritten segments keep their stored parity, so an existing error is
    // not silently repaired by a partial write.
    assign wr_par  = (merged_par & wmask0_q) | (par_mem_q[addr0_q] & ~wmask0_q);
    assign stored0 = par_mem_q[addr0_q];
    assign stored1 = coll1_d ? merged_par : par_mem_q[addr1_q];

    for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_chk
        logic [SRAM_MAX_SEG-1:0] ext0, ext1;
        always_comb begin
            ext0                  = '0;
            ext1                  = '0;
            ext0[WMASK_WIDTH-1:0] = word0[g*WMASK_WIDTH +: WMASK_WIDTH];
            ext1[WMASK_WIDTH-1:0] = rd1_data[g*WMASK_WIDTH +: WMASK_WIDTH];
        end
        assign chk0[g] = seg_parity(ext0);
        assign chk1[g] = seg_parity(ext1);
    end

    assign perr0_chk = |(chk0 ^ stored0);
    assign perr1_chk = |(chk1 ^ stored1);

    always_ff @(negedge clk0) begin
        if (wr0) begin
            par_mem_q[addr0_q] <= wr_par;
        end
    end

    assign perr0 = resp0_q.perr;
    assign perr1 = resp1_q.perr;
`else
    logic unused_par;
    assign unused_par = ^merged_par;
    assign perr0_chk  = 1'b0;
    assign perr1_chk  = 1'b0;
    assign perr0      = 1'b0;
    assign perr1      = 1'b0;
`endif

    // Array is deliberately not reset.
    always_ff @(negedge clk0) begin
        if (wr0) begin
            mem_q[addr0_q] <= merged;
        end
    end

    // Data holds across idle/write cycles; valid and perr are per-cycle.
    always_comb begin
        resp0_d       = resp0_q;
        resp0_d.valid = rd0;
        resp0_d.perr  = rd0 && perr0_chk;
        if (rd0) begin
            resp0_d.data[DATA_WIDTH-1:0] = word0;
        end

        resp1_d       = resp1_q;
        resp1_d.valid = rd1;
        resp1_d.perr  = rd1 && perr1_chk;
        if (rd1) begin
            resp1_d.data[DATA_WIDTH-1:0] = rd1_data;
        end
    end

    always_ff @(negedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            resp0_q <= '0;
            resp1_q <= '0;
            coll1_q <= 1'b0;
        end else begin
            resp0_q <= resp0_d;
            resp1_q <= resp1_d;
            coll1_q <= coll1_d;
        end
    end

    assign dout0   = resp0_q.data[DATA_WIDTH-1:0];
    assign rvalid0 = resp0_q.valid;
    assign dout1   = resp1_q.data[DATA_WIDTH-1:0];
    assign rvalid1 = resp1_q.valid;
    assign coll1   = coll1_q;

    logic unused_resp;
    assign unused_resp = ^{resp0_q, resp1_q};

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// tb/tb_sram_1rw1r_wmask.sv - directed self-checking bench for sram_1rw1r_wmask
module tb_sram_1rw1r_wmask;

    logic        clk0 = 1'b0;
    logic        rst0_n;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [6:0]  addr0, addr1;
    logic [31:0] din0, dout0, dout1;
    logic        rvalid0, rvalid1, coll1, perr0, perr1;

    int errors = 0;
    int checks = 0;

    sram_1rw1r_wmask dut (
        .clk0    (clk0),
        .rst0_n  (rst0_n),
        .csb0    (csb0),
        .web0    (web0),
        .wmask0  (wmask0),
        .addr0   (addr0),
        .din0    (din0),
        .dout0   (dout0),
        .rvalid0 (rvalid0),
        .csb1    (csb1),
        .addr1   (addr1),
        .dout1   (dout1),
        .rvalid1 (rvalid1),
        .coll1   (coll1),
        .perr0   (perr0),
        .perr1   (perr1)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic p0_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask

    task automatic p0_read(input logic [6:0] a);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a; wmask0 = 4'h0;
    endtask

    task automatic p0_idle();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0;
    endtask

    task automatic p1_read(input logic [6:0] a);
        csb1 = 1'b0; addr1 = a;
    endtask

    task automatic p1_idle();
        csb1 = 1'b1;
    endtask

    initial begin
        rst0_n = 1'b0;
        p0_idle(); p1_idle();
        addr0 = '0; addr1 = '0; din0 = '0;
        #2;
        chk("rst_dout0", dout0, 32'h0);
        chk("rst_rvalid0", {31'b0, rvalid0}, 32'h0);
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_rvalid1", {31'b0, rvalid1}, 32'h0);
        chk("rst_coll1", {31'b0, coll1}, 32'h0);
        step(); step();
        rst0_n = 1'b1;
        step();

        // Seed 0x05, then same-address read on both ports (no collision).
        p0_write(7'h05, 32'h55AA55AA, 4'hF); step();
        p0_read(7'h05); p1_read(7'h05); step();
        p0_idle(); p1_idle(); step();
        chk("dual_rd_dout0", dout0, 32'h55AA55AA);
        chk("dual_rd_dout1", dout1, 32'h55AA55AA);
        chk("dual_rd_rvalid1", {31'b0, rvalid1}, 32'h1);
        chk("dual_rd_coll1", {31'b0, coll1}, 32'h0);

        // Mid-cycle async reset squashes the captured write.
        p0_write(7'h05, 32'h12345678, 4'hF);
        @(posedge clk0); #2;
        rst0_n = 1'b0;
        #1;
        chk("midrst_dout0", dout0, 32'h0);
        chk("midrst_dout1", dout1, 32'h0);
        chk("midrst_rvalid0", {31'b0, rvalid0}, 32'h0);
        p0_idle();
        @(negedge clk0); #1;
        rst0_n = 1'b1;
        step();
        p0_read(7'h05); step();
        p0_idle(); step();
        chk("midrst_keep_05", dout0, 32'h55AA55AA);

        // Full write and one-cycle rvalid0.
        p0_write(7'h10, 32'hDEADBEEF, 4'hF); step();
        p0_read(7'h10); step();
        p0_idle(); step();
        chk("wr_rd_dout0", dout0, 32'hDEADBEEF);
        chk("wr_rd_rvalid0", {31'b0, rvalid0}, 32'h1);
        chk("wr_rd_perr0", {31'b0, perr0}, 32'h0);
        step();
        chk("rvalid0_drop", {31'b0, rvalid0}, 32'h0);
        chk("dout0_hold", dout0, 32'hDEADBEEF);

        // Masked write, port-1 readback.
        p0_write(7'h10, 32'h11223344, 4'b0101); step();
        p0_idle(); p1_read(7'h10); step();
        p1_idle(); step();
        chk("mask_dout1", dout1, 32'hDE22BE44);
        chk("mask_rvalid1", {31'b0, rvalid1}, 32'h1);
        chk("mask_coll1", {31'b0, coll1}, 32'h0);
        chk("mask_perr1", {31'b0, perr1}, 32'h0);

        // Full-mask collision.
        p0_write(7'h20, 32'hCAFEF00D, 4'hF); p1_read(7'h20); step();
        p0_idle(); p1_idle(); step();
        chk("coll_dout1", dout1, 32'hCAFEF00D);
        chk("coll_flag", {31'b0, coll1}, 32'h1);
        chk("coll_rvalid0", {31'b0, rvalid0}, 32'h0);
        step();
        chk("coll_flag_drop", {31'b0, coll1}, 32'h0);
        chk("coll_rvalid1_drop", {31'b0, rvalid1}, 32'h0);
        chk("coll_dout1_hold", dout1, 32'hCAFEF00D);

        // Partial-mask collision forwards the merged word.
        p0_write(7'h20, 32'h00001111, 4'b0011); p1_read(7'h20); step();
        p0_idle(); p1_idle(); step();
        chk("pcoll_dout1", dout1, 32'hCAFE1111);
        chk("pcoll_flag", {31'b0, coll1}, 32'h1);
        chk("pcoll_perr1", {31'b0, perr1}, 32'h0);
        p0_read(7'h20); step();
        p0_idle(); step();
        chk("pcoll_array", dout0, 32'hCAFE1111);

        // Zero-mask write leaves the word alone; writes do not move dout0.
        p0_write(7'h10, 32'hFFFFFFFF, 4'h0); step();
        p0_idle(); step();
        chk("zmask_dout0_hold", dout0, 32'hCAFE1111);

        // 20 back-to-back reads.
        p0_read(7'h10); step();
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("b2b_rvalid0_%0d", i), {31'b0, rvalid0}, 32'h1);
            chk($sformatf("b2b_dout0_%0d", i), dout0, 32'hDE22BE44);
        end
        p0_write(7'h10, 32'h0BADC0DE, 4'hF); step();
        p0_idle(); p1_read(7'h10); step();
        p1_idle(); step();
        chk("post_b2b_write", dout1, 32'h0BADC0DE);

`ifdef SRAM_PARITY_EN
        p0_write(7'h30, 32'hA5A5A5A5, 4'hF); step();
        p0_idle(); step();
        dut.mem_q[7'h30][0] = ~dut.mem_q[7'h30][0];
        p0_read(7'h30); p1_read(7'h30); step();
        p0_idle(); p1_idle(); step();
        chk("par_perr1", {31'b0, perr1}, 32'h1);
        chk("par_rvalid1", {31'b0, rvalid1}, 32'h1);
        chk("par_perr0", {31'b0, perr0}, 32'h1);
        step();
        chk("par_perr1_clear", {31'b0, perr1}, 32'h0);
        p1_read(7'h10); step();
        p1_idle(); step();
        chk("par_clean_perr1", {31'b0, perr1}, 32'h0);
        chk("par_clean_rvalid1", {31'b0, rvalid1}, 32'h1);
`else
        p0_read(7'h10); p1_read(7'h10); step();
        p0_idle(); p1_idle(); step();
        chk("nopar_perr0", {31'b0, perr0}, 32'h0);
        chk("nopar_perr1", {31'b0, perr1}, 32'h0);
        chk("nopar_rvalid1", {31'b0, rvalid1}, 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
